// File: rtl/rocstar_coinc_event_fifo.sv
// rocstar_coinc_event_fifo
// Keeps the board's free-running clock counter and a snapshot register.
// Timestamps coincidence pulses from the MCU link and buffers them in a
// first-word-fall-through FIFO that readout drains with valid/ready.
//
// Ports:
//   clk, rst_n           : system clock, synchronous active-low reset
//   runmode              : event capture enable
//   sync_clk, save_clk   : zero clkcnt / snapshot clkcnt into clksav
//   pcoinc/dcoinc/ncoinc : single-cycle coincidence pulses
//   clkcnt, clksav       : clock counter and last snapshot
//   ev_valid/ev_ready    : FIFO head handshake
//   ev_data              : {type[1:0], timestamp[CW-1:0]} (01=p, 10=d, 11=n)
//   ev_count             : FIFO occupancy
//   drop_cnt, multi_cnt  : saturating overflow and multi-coinc counters
module rocstar_coinc_event_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     runmode,
  input  logic                     sync_clk,
  input  logic                     save_clk,
  input  logic                     pcoinc,
  input  logic                     dcoinc,
  input  logic                     ncoinc,
  output logic [CW-1:0]            clkcnt,
  output logic [CW-1:0]            clksav,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [CW+1:0]            ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              multi_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned DW   = CW + 2;

  logic [CW-1:0]   clkcnt_q, clkcnt_d;
  logic [CW-1:0]   clksav_q, clksav_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            ev_valid_q, ev_valid_d;
  logic [DW-1:0]   ev_data_q, ev_data_d;
  logic [15:0]     drop_q, drop_d;
  logic [15:0]     multi_q, multi_d;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            pop_c;
  logic            want_c;
  logic            full_c;
  logic            push_c;
  logic            drop_c;
  logic            multi_c;
  logic [1:0]      ev_type_c;
  logic [DW-1:0]   entry_c;

  // Next-state logic for counter, snapshot, FIFO pointers and head register
  always_comb begin
    pop_c     = ev_valid_q & ev_ready;
    want_c    = runmode & (pcoinc | dcoinc | ncoinc);
    full_c    = (count_q == CNTW'(DEPTH));
    push_c    = want_c & (~full_c | pop_c);
    drop_c    = want_c & full_c & ~pop_c;
    multi_c   = (pcoinc & dcoinc) | (pcoinc & ncoinc) | (dcoinc & ncoinc);
    ev_type_c = pcoinc ? 2'b01 : (dcoinc ? 2'b10 : 2'b11);
    entry_c   = {ev_type_c, clkcnt_q};

    clkcnt_d  = sync_clk ? '0 : clkcnt_q + CW'(1);
    clksav_d  = save_clk ? clkcnt_q : clksav_q;

    wr_ptr_d  = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d   = count_q;
    if (push_c && !pop_c) count_d = count_q + CNTW'(1);
    if (pop_c && !push_c) count_d = count_q - CNTW'(1);

    ev_valid_d = (count_d != '0);
    // The entry being written becomes the head when it lands where the
    // read pointer will point next (FIFO empty after this cycle's pop).
    ev_data_d  = (push_c && (wr_ptr_q == rd_ptr_d)) ? entry_c : mem_q[rd_ptr_d];

    drop_d    = (drop_c  && drop_q  != 16'hFFFF) ? drop_q  + 16'd1 : drop_q;
    multi_d   = (multi_c && multi_q != 16'hFFFF) ? multi_q + 16'd1 : multi_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clkcnt_q   <= '0;
      clksav_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
      drop_q     <= '0;
      multi_q    <= '0;
    end else begin
      clkcnt_q   <= clkcnt_d;
      clksav_q   <= clksav_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
      drop_q     <= drop_d;
      multi_q    <= multi_d;
    end
  end

  // FIFO storage; contents are irrelevant until a pointer reaches them
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= entry_c;
  end

  assign clkcnt    = clkcnt_q;
  assign clksav    = clksav_q;
  assign ev_valid  = ev_valid_q;
  assign ev_data   = ev_data_q;
  assign ev_count  = count_q;
  assign drop_cnt  = drop_q;
  assign multi_cnt = multi_q;

endmodule
